conv_layer_scheduler: RTL

//  Sequences one conv+pool layer: steps (out_ch, in_ch) pairs, requests kernel loads, and runs the
//  2-D anchor generator for one full feature-map sweep per pair. Sits between the layer control
//  FSM and the anchor generator / MAC datapath.

---
 rtl/conv_layer_scheduler_if.sv | 34 +++
 rtl/conv_layer_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/conv_layer_scheduler_if.sv
// Control/handshake bundle between the layer controller, the conv layer
// scheduler, the kernel buffer, the anchor generator and the MAC datapath.
interface conv_layer_scheduler_if;
    logic       start;
    logic       abort;
    logic [7:0] cfg_in_ch;
    logic [7:0] cfg_out_ch;
    logic       wload_req;
    logic       wload_done;
    logic       gen_enable;
    logic       gen_pause;
    logic       anchor_valid;
    logic       out_ready;
    logic       acc_clear;
    logic       acc_last;
    logic [7:0] ch_in_idx;
    logic [7:0] ch_out_idx;
    logic       busy;
    logic       done;

    // Controller / environment side
    modport master (
        output start, abort, cfg_in_ch, cfg_out_ch, wload_done, out_ready,
        input  wload_req, gen_enable, gen_pause, anchor_valid, acc_clear, acc_last,
               ch_in_idx, ch_out_idx, busy, done
    );

    // Scheduler side
    modport slave (
        input  start, abort, cfg_in_ch, cfg_out_ch, wload_done, out_ready,
        output wload_req, gen_enable, gen_pause, anchor_valid, acc_clear, acc_last,
               ch_in_idx, ch_out_idx, busy, done
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Conv+pool layer scheduler: walks (out_ch, in_ch) pairs, requests a kernel
// load for each pair, then drives one full anchor sweep through the datapath,
// waits for the pipeline to drain and moves on. Outputs are decoded from the
// state register so an asynchronous reset clears them immediately.
module conv_layer_scheduler #(
    parameter int DATA_HEIGHT   = 35,
    parameter int DATA_WIDTH    = 35,
    parameter int KERNAL_HEIGHT = 5,
    parameter int KERNAL_WIDTH  = 5,
    parameter int PIPE_LAT      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv_layer_scheduler_if.slave  bus
);
    localparam int ANCHORS = (DATA_HEIGHT - KERNAL_HEIGHT + 1) * (DATA_WIDTH - KERNAL_WIDTH + 1);
    // Counters only need to reach ANCHORS-1 and PIPE_LAT-1
    localparam int ACNT_W  = (ANCHORS  > 1) ? $clog2(ANCHORS)  : 1;
    localparam int DCNT_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ACNT_W-1:0] ANCHOR_LAST = ACNT_W'(ANCHORS - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST  = DCNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ACNT_W-1:0]   anchor_cnt_q, anchor_cnt_d;
    logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [7:0]          in_cfg_q, in_cfg_d;
    logic [7:0]          out_cfg_q, out_cfg_d;
    logic [7:0]          ch_in_q, ch_in_d;
    logic [7:0]          ch_out_q, ch_out_d;

    logic [7:0] in_last;
    logic [7:0] out_last;
    logic       in_run;

    assign in_last  = in_cfg_q - 8'd1;
    assign out_last = out_cfg_q - 8'd1;
    assign in_run   = (state_q == S_RUN);

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            anchor_cnt_q <= '0;
            drain_cnt_q  <= '0;
            in_cfg_q     <= 8'd0;
            out_cfg_q    <= 8'd0;
            ch_in_q      <= 8'd0;
            ch_out_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            anchor_cnt_q <= anchor_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            in_cfg_q     <= in_cfg_d;
            out_cfg_q    <= out_cfg_d;
            ch_in_q      <= ch_in_d;
            ch_out_q     <= ch_out_d;
        end
    end

    // Next-state: pair sequencing, anchor counting, drain wait; abort overrides all
    always_comb begin
        state_d      = state_q;
        anchor_cnt_d = anchor_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        in_cfg_d     = in_cfg_q;
        out_cfg_d    = out_cfg_q;
        ch_in_d      = ch_in_q;
        ch_out_d     = ch_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // A channel count of 0 is run as a single channel
                    in_cfg_d  = (bus.cfg_in_ch  == 8'd0) ? 8'd1 : bus.cfg_in_ch;
                    out_cfg_d = (bus.cfg_out_ch == 8'd0) ? 8'd1 : bus.cfg_out_ch;
                    ch_in_d   = 8'd0;
                    ch_out_d  = 8'd0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.wload_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.out_ready) begin
                    if (anchor_cnt_q == ANCHOR_LAST) begin
                        // Dropping gen_enable next cycle rewinds the generator to (0,0)
                        anchor_cnt_d = '0;
                        drain_cnt_d  = '0;
                        state_d      = S_DRAIN;
                    end else begin
                        anchor_cnt_d = anchor_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    if (ch_in_q < in_last) begin
                        ch_in_d = ch_in_q + 8'd1;
                        state_d = S_LOAD;
                    end else begin
                        ch_in_d = 8'd0;
                        if (ch_out_q < out_last) begin
                            ch_out_d = ch_out_q + 8'd1;
                            state_d  = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d      = S_IDLE;
            anchor_cnt_d = '0;
            drain_cnt_d  = '0;
            ch_in_d      = 8'd0;
            ch_out_d     = 8'd0;
        end
    end

    assign bus.wload_req    = (state_q == S_LOAD);
    assign bus.gen_enable   = in_run;
    assign bus.anchor_valid = in_run;
    assign bus.gen_pause    = in_run && !bus.out_ready;
    assign bus.acc_clear    = in_run && (ch_in_q == 8'd0);
    assign bus.acc_last     = in_run && (ch_in_q == in_last);
    assign bus.ch_in_idx    = ch_in_q;
    assign bus.ch_out_idx   = ch_out_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
endmodule
